ifetch_prefetch: RTL

IFETCH_PREFETCH -- requirements
Module: ifetch_prefetch

---
 rtl/ifetch_prefetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ifetch_prefetch.sv
// Instruction prefetcher: Wishbone read master doing sequential word fetches
// into a small {pc, instr} queue, with redirect (flush/restart) support.
module ifetch_prefetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic        wb_ack_i,
    input  logic [31:0] wb_dat_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, BUS, DISCARD} state_e;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     adr_q, adr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     pc_mem  [DEPTH];
    logic [31:0]     ins_mem [DEPTH];
    logic [31:0]     redirect_pc;
    logic            push, pop;

    assign redirect_pc = {redirect_pc_i[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        adr_d      = adr_q;
        push       = 1'b0;
        pop        = (count_q != '0) && instr_ready_i && !redirect_i;
        case (state_q)
            IDLE: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                end else if (count_q < CW'(DEPTH)) begin
                    // Nothing is in flight in IDLE, so occupancy alone bounds the queue.
                    state_d = BUS;
                    adr_d   = fetch_pc_q;
                end
            end
            BUS: begin
                if (redirect_i) begin
                    fetch_pc_d = redirect_pc;
                    state_d    = wb_ack_i ? IDLE : DISCARD;
                end else if (wb_ack_i) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    state_d    = IDLE;
                end
            end
            DISCARD: begin
                // The started read cannot be aborted; wait for its ack and drop it.
                if (redirect_i) fetch_pc_d = redirect_pc;
                if (wb_ack_i)   state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally.
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            adr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            adr_q      <= adr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]  <= fetch_pc_q;
            ins_mem[wr_ptr_q] <= wb_dat_i;
        end
    end

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = instr_valid_o ? ins_mem[rd_ptr_q] : 32'd0;
    assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr_q]  : 32'd0;

    assign wb_stb_o = (state_q != IDLE);
    assign wb_cyc_o = wb_stb_o;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = 32'd0;
    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'hF;

endmodule
